// File: rtl/pipeline_ctrl_pkg.sv
// Shared CPU control definitions: memory-wait FSM encoding, register
// address type and the default data-memory timeout.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } ctrl_state_t;

  typedef logic [4:0] reg_addr_t;

  localparam int DEFAULT_MEM_TIMEOUT = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection: the load in EX writes a register that the
// instruction in ID reads. Register x0 never creates a hazard.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  reg_addr_t id_rs1_address,
  input  reg_addr_t id_rs2_address,
  input  logic      id_uses_rs1,
  input  logic      id_uses_rs2,
  input  reg_addr_t ex_rd_address,
  input  logic      ex_mem_read,
  output logic      load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (ex_rd_address == id_rs1_address);
  assign rs2_hit  = id_uses_rs2 && (ex_rd_address == id_rs2_address);
  assign load_use = ex_mem_read && (ex_rd_address != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: prioritises memory freeze, branch flush
// and load-use bubbles, tracks data-memory timeouts and counts stalls/flushes.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_address,
  input  logic [4:0]       id_rs2_address,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_address,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_t      state_q;
  logic [WC_W-1:0]  wait_cnt_q;
  logic             mem_error_q;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             load_use;
  logic             mem_pending;
  logic             freeze;

  hazard_detect u_hazard_detect (
    .id_rs1_address (id_rs1_address),
    .id_rs2_address (id_rs2_address),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd_address  (ex_rd_address),
    .ex_mem_read    (ex_mem_read),
    .load_use       (load_use)
  );

  assign mem_pending = mem_req && !dmem_ack;
  assign freeze      = mem_pending || (state_q == ERROR);

  // A branch seen during a freeze needs no storage: EX is held, so the
  // branch is still presented once the freeze lifts.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        pipe_freeze = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_pending) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_req || dmem_ack) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
            state_q     <= ERROR;
            mem_error_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WC_W'(1);
          end
        end
        ERROR: begin
          mem_error_q <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign stall_cycles_d = (pc_stall && (stall_cycles_q != '1)) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
  assign flush_count_d  = (if_id_flush && (flush_count_q != '1)) ? flush_count_q + CNT_W'(1) : flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_error    = mem_error_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (CNT_W = 4 so saturation is reachable).
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs1_address = '0, id_rs2_address = '0, ex_rd_address = '0;
  logic          id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0;
  logic          ex_branch_taken = 0, mem_req = 0, dmem_ack = 0;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, mem_error;
  logic [CW-1:0] stall_cycles, flush_count;

  pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_address(ex_rd_address), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ack(dmem_ack),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pipe_freeze(pipe_freeze), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [5:0]    flags;  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, mem_error}
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [5:0] F_NONE   = 6'b000000;
  localparam logic [5:0] F_LU     = 6'b110100;
  localparam logic [5:0] F_BR     = 6'b001100;
  localparam logic [5:0] F_FRZ    = 6'b110010;
  localparam logic [5:0] F_ERR    = 6'b110011;

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic step(input string name, input logic r,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic br,
                      input logic mq, input logic ak,
                      input logic [5:0] flags, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    id_rs1_address = rs1; id_uses_rs1 = u1;
    id_rs2_address = rs2; id_uses_rs2 = u2;
    ex_rd_address = rd; ex_mem_read = mr; ex_branch_taken = br;
    mem_req = mq; dmem_ack = ak;
    e.name = name; e.flags = flags; e.sc = CW'(sc); e.fc = CW'(fc);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] got;
      e = exp_q.pop_front();
      got = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_freeze, mem_error};
      checks++;
      if (got !== e.flags || stall_cycles !== e.sc || flush_count !== e.fc) begin
        errors++;
        $display("FAIL %s: got flags=%b sc=%0d fc=%0d, expected flags=%b sc=%0d fc=%0d",
                 e.name, got, stall_cycles, flush_count, e.flags, e.sc, e.fc);
      end else begin
        $display("check %s: flags=%b sc=%0d fc=%0d ok", e.name, got, stall_cycles, flush_count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset holds every stall/flush low even with hazards and a pending access presented.
    step("reset_outputs", 1, 5'd5, 1, 0, 0, 5'd5, 1, 1, 1, 0, F_NONE, 0, 0);
    step("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 0);
    step("load_use_rs1",  0, 5'd5, 1, 0, 0, 5'd5, 1, 0, 0, 0, F_LU, 0, 0);
    step("after_lu",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 1, 0);
    step("x0_no_stall",   0, 5'd0, 1, 0, 0, 5'd0, 1, 0, 0, 0, F_NONE, 1, 0);
    step("rs2_unused",    0, 5'd3, 1, 5'd7, 0, 5'd7, 1, 0, 0, 0, F_NONE, 1, 0);
    step("no_load",       0, 5'd7, 1, 5'd7, 1, 5'd7, 0, 0, 0, 0, F_NONE, 1, 0);
    step("load_use_rs2",  0, 5'd3, 1, 5'd7, 1, 5'd7, 1, 0, 0, 0, F_LU, 1, 0);
    step("branch_over_lu",0, 5'd3, 1, 5'd7, 1, 5'd7, 1, 1, 0, 0, F_BR, 2, 0);
    step("after_branch",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 2, 1);
    // Memory wait of 3 cycles with a branch held underneath the freeze.
    step("wait1_br",      0, 0, 0, 0, 0, 0, 0, 1, 1, 0, F_FRZ, 2, 1);
    step("wait2_br",      0, 0, 0, 0, 0, 0, 0, 1, 1, 0, F_FRZ, 3, 1);
    step("wait3",         0, 0, 0, 0, 0, 0, 0, 0, 1, 0, F_FRZ, 4, 1);
    step("ack_branch",    0, 0, 0, 0, 0, 0, 0, 1, 1, 1, F_BR, 5, 1);
    step("back_in_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 5, 2);
    step("ack_no_req",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, F_NONE, 5, 2);
    step("rst_pulse1",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 0);
    step("lu_after_rst",  0, 5'd9, 1, 0, 0, 5'd9, 1, 0, 0, 0, F_LU, 0, 0);
    // Timeout: error registers after the 17th unacknowledged cycle; counter saturates at 15.
    for (int i = 1; i <= 20; i++) begin
      step($sformatf("timeout_c%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
           (i >= 18) ? F_ERR : F_FRZ, (i >= 16) ? 15 : i, 0);
    end
    step("err_stuck_idle",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_ERR, 15, 0);
    step("err_stuck_br",  0, 0, 0, 0, 0, 0, 0, 1, 0, 1, F_ERR, 15, 0);
    step("err_stuck_ack", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, F_ERR, 15, 0);
    step("rst_pulse2",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, F_NONE, 0, 0);
    step("run_after_err", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 0);
    step("branch_run",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, F_BR, 0, 0);
    step("final_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, F_NONE, 0, 1);
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of consecutive data-memory wait cycles before error.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports id_rs1_address and id_rs2_address, input, 5 bits each: source registers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1 bit each: the ID instruction actually reads that source.
REQ-007 SHALL have ports ex_rd_address (input, 5 bits) and ex_mem_read (input, 1 bit): destination of the EX instruction, and whether that instruction is a load.
REQ-008 SHALL have port ex_branch_taken, input, 1 bit: a taken branch or jump is resolved in EX this cycle.
REQ-009 SHALL have ports mem_req and dmem_ack, input, 1 bit each: the MEM stage is accessing data memory, and memory completes the access this cycle.
REQ-010 SHALL have ports pc_stall and if_id_stall, output, 1 bit each: hold the PC, and hold the IF/ID register.
REQ-011 SHALL have ports if_id_flush and id_ex_flush, output, 1 bit each: load a bubble into IF/ID, and load a bubble into ID/EX.
REQ-012 SHALL have port pipe_freeze, output, 1 bit: hold the ID/EX, EX/MEM and MEM/WB registers.
REQ-013 SHALL have port mem_error, output, 1 bit: a data-memory timeout occurred (sticky).
REQ-014 SHALL have ports stall_cycles and flush_count, output, CNT_W bits each: performance counters.

Function
REQ-015 SHALL define freeze = mem_req & ~dmem_ack, or state == ERROR.
REQ-016 SHALL define load_use = ex_mem_read & (ex_rd_address != 0) & ((id_uses_rs1 & ex_rd_address == id_rs1_address) | (id_uses_rs2 & ex_rd_address == id_rs2_address)).
REQ-017 SHALL apply this priority, highest first: freeze, then ex_branch_taken, then load_use, then normal.
REQ-018 SHALL, on freeze, assert pc_stall, if_id_stall and pipe_freeze, and deassert both flush outputs, all combinationally in the same cycle.
REQ-019 SHALL, on branch without freeze, assert if_id_flush and id_ex_flush, deassert all stall outputs, and ignore load_use.
REQ-020 SHALL, on load_use without freeze or branch, assert pc_stall, if_id_stall and id_ex_flush for exactly that cycle (one bubble), with pipe_freeze = 0.
REQ-021 SHALL hold a taken branch that coincides with freeze: EX is held, so the flush takes effect in the first unfrozen cycle; no extra storage is needed.
REQ-022 SHALL implement an FSM with states RUN, MEM_WAIT and ERROR; the reset state is RUN.
REQ-023 SHALL, in RUN, move to MEM_WAIT with wait_cnt = 1 when mem_req & ~dmem_ack.
REQ-024 SHALL, in MEM_WAIT, return to RUN with wait_cnt cleared on dmem_ack or when mem_req drops; otherwise it increments wait_cnt.
REQ-025 SHALL, in MEM_WAIT, move to ERROR when wait_cnt == MEM_TIMEOUT and ack is still absent.
REQ-026 SHALL, in ERROR, set mem_error = 1 and force all stall outputs high; ERROR exits only by reset.
REQ-027 SHALL increment stall_cycles on every cycle in which pc_stall = 1, saturating at all-ones with no wrap.
REQ-028 SHALL increment flush_count on every cycle in which if_id_flush = 1, saturating at all-ones.
REQ-029 SHALL treat dmem_ack without mem_req as a no-op.

Reset
REQ-030 SHALL, on rst asserted, asynchronously force state = RUN, wait_cnt = 0, mem_error = 0 and both counters = 0.
REQ-031 SHALL, while rst is high, drive all stall and flush outputs to 0.
REQ-032 SHALL, on reset during MEM_WAIT or ERROR, abandon the wait; after release, control resumes from RUN on the next edge.

Structure
REQ-033 SHALL put the state encoding (RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2) and the default MEM_TIMEOUT in the shared CPU package.
REQ-034 SHALL contain one natural sub-module, hazard_detect, which is purely combinational (load_use); the FSM and counters live in pipeline_ctrl.

Verification
REQ-035 SHALL cover load-use: ex_mem_read = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 -> pc_stall = if_id_stall = id_ex_flush = 1 for one cycle, and stall_cycles = 1.
REQ-036 SHALL cover x0 and unused source: ex_rd = 0 with a matching rs, or id_uses_rs2 = 0 with rs2 matching -> no stall.
REQ-037 SHALL cover branch with load_use in the same cycle: both flushes = 1, pc_stall = 0, and flush_count = 1.
REQ-038 SHALL cover memory wait: mem_req = 1 with ack low for 3 cycles, then ack -> pipe_freeze = 1 for 3 cycles, 0 in the ack cycle, and FSM back in RUN.
REQ-039 SHALL cover timeout: mem_req = 1 with no ack for 17 cycles -> mem_error = 1 and outputs stuck; rst pulse -> mem_error = 0, counters = 0, state RUN.
REQ-040 SHALL cover saturation: with CNT_W = 4, stall for 20 cycles -> stall_cycles = 15.
